// File: rtl/pe_seq_pkg.sv
// Shared definitions for the MHA PE-array tile sequencers: FSM states,
// pipeline latency helper and the default accumulator staging depth.
package pe_seq_pkg;

    localparam int STAGE_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_WT = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Row issue to result valid: the systolic skew plus the accumulator staging.
    function automatic int pipe_lat(input int depth, input int column, input int stg);
        return depth + column - 1 + stg;
    endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// Fixed-latency valid shift register; never stalls, cleared synchronously by clr.
module pe_valid_pipe #(
    parameter int DEPTH = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in,
    output logic out
);

    logic [DEPTH:1] vld_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_pipe <= '0;
        else if (clr)
            vld_pipe <= '0;
        else
            vld_pipe <= DEPTH'({vld_pipe, in});
    end

    assign out = vld_pipe[DEPTH];

endmodule

// File: rtl/pe_blk_sequencer.sv
// Sequences one tile through the PE array: weight load, row streaming and
// pipeline drain, with a res_valid strobe aligned to the staged acc_out.
module pe_blk_sequencer
    import pe_seq_pkg::*;
#(
    parameter int bit_width       = 8,
    parameter int systolic_depth  = 4,
    parameter int systolic_column = 16,
    parameter int stage_lat       = STAGE_LAT_DEF,
    parameter int row_width       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [row_width-1:0] cfg_rows,
    input  logic                 abort,
    input  logic                 wt_valid,
    output logic                 wt_ready,
    input  logic                 dat_valid,
    output logic                 dat_ready,
    output logic                 is_wt,
    output logic                 dat_en,
    output logic                 res_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int PIPE_LAT = pipe_lat(systolic_depth, systolic_column, stage_lat);
    localparam int WCW      = $clog2(systolic_depth) + 1;
    localparam logic [WCW-1:0] WT_LAST = WCW'(systolic_depth - 1);

    if (bit_width < 1 || systolic_depth < 1 || systolic_column < 1 || row_width < 1 ||
        PIPE_LAT < 1) begin : g_bad_param
        $error("pe_blk_sequencer: invalid parameter set");
    end

    state_t               state;
    logic [row_width-1:0] rows_q;
    logic [row_width-1:0] in_cnt;
    logic [row_width-1:0] out_cnt;
    logic [row_width-1:0] out_cnt_nxt;
    logic [WCW-1:0]       wt_cnt;

    // Readies decode from state only, so valid never loops back into ready.
    assign wt_ready  = (state == ST_LOAD_WT);
    assign dat_ready = (state == ST_STREAM);
    assign is_wt     = wt_valid & wt_ready;
    assign dat_en    = dat_valid & dat_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    assign out_cnt_nxt = out_cnt + row_width'(res_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            rows_q  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            wt_cnt  <= '0;
        end else if (abort) begin
            state   <= ST_IDLE;
            rows_q  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            wt_cnt  <= '0;
        end else begin
            // Results can land during STREAM for long tiles, so count everywhere.
            if (res_valid)
                out_cnt <= out_cnt_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_q  <= cfg_rows;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        wt_cnt  <= '0;
                        state   <= ST_LOAD_WT;
                    end
                end
                ST_LOAD_WT: begin
                    if (is_wt) begin
                        wt_cnt <= wt_cnt + 1'b1;
                        if (wt_cnt == WT_LAST)
                            state <= (rows_q != '0) ? ST_STREAM : ST_DONE;
                    end
                end
                ST_STREAM: begin
                    if (dat_en) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt + 1'b1 == rows_q)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_cnt_nxt == rows_q)
                        state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    pe_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_vld_pipe (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .in    (dat_en),
        .out   (res_valid)
    );

endmodule

// File: tb/tb_pe_blk_sequencer.sv
// Directed bench for pe_blk_sequencer: basic, stalled, empty, aborted, reset and max-size tiles.
module tb_pe_blk_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] cfg_rows;
    logic       abort;
    logic       wt_valid, wt_ready;
    logic       dat_valid, dat_ready;
    logic       is_wt, dat_en, res_valid, busy, done;

    pe_blk_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .abort     (abort),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .is_wt     (is_wt),
        .dat_en    (dat_en),
        .res_valid (res_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, ph = 0;
    int n_wt, n_den, n_res, n_done;
    int first_den, first_res, last_res, done_cyc, start_cyc;
    int pipe_err;
    bit pipe_on = 1'b0;
    bit wt_tog = 1'b0, dat_bub = 1'b0;
    bit den_hist [8192];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        den_hist[cyc % 8192] = dat_en;
        if (pipe_on && cyc >= 20 && res_valid != den_hist[(cyc - 20) % 8192]) pipe_err++;
        if (is_wt) n_wt++;
        if (dat_en) begin
            n_den++;
            if (first_den < 0) first_den = cyc;
        end
        if (res_valid) begin
            n_res++;
            if (first_res < 0) first_res = cyc;
            last_res = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic clr_mon();
        n_wt = 0; n_den = 0; n_res = 0; n_done = 0; pipe_err = 0;
        first_den = -1; first_res = -1; last_res = -1; done_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph++;
        wt_valid  = wt_tog  ? ph[0] : 1'b1;
        dat_valid = dat_bub ? (ph % 3 == 0) : 1'b1;
    endtask

    task automatic issue(input int rows);
        clr_mon();
        tick();
        cfg_rows  = 10'(rows);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, int'(n_done > 0), 1);
        tick();
        tick();
    endtask

    function automatic int outs();
        return {is_wt, dat_en, res_valid, busy, done, wt_ready, dat_ready};
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_rows = '0;
        wt_valid = 1'b0; dat_valid = 1'b0;
        clr_mon();
        repeat (3) tick();
        chk("reset_outs", outs(), 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);

        // basic tile, 8 rows, no stalls
        issue(8);
        wait_done("basic", 200);
        chk("basic_wt",    n_wt, 4);
        chk("basic_den",   n_den, 8);
        chk("basic_res",   n_res, 8);
        chk("basic_lat",   first_res - first_den, 20);
        chk("basic_run",   last_res - first_res, 7);
        chk("basic_done1", done_cyc - last_res, 1);
        chk("basic_len",   done_cyc - start_cyc + 1, 34);
        chk("basic_ndone", n_done, 1);

        // stalls on both handshakes
        wt_tog = 1'b1; dat_bub = 1'b1; pipe_on = 1'b1;
        issue(5);
        wait_done("stall", 300);
        chk("stall_wt",   n_wt, 4);
        chk("stall_res",  n_res, 5);
        chk("stall_lat",  first_res - first_den, 20);
        chk("stall_pipe", pipe_err, 0);
        wt_tog = 1'b0; dat_bub = 1'b0; pipe_on = 1'b0;

        // zero rows: weights only
        issue(0);
        wait_done("zero", 100);
        chk("zero_wt",  n_wt, 4);
        chk("zero_den", n_den, 0);
        chk("zero_res", n_res, 0);
        chk("zero_len", done_cyc - start_cyc, 5);

        // abort mid-stream
        issue(10);
        begin
            int k = 0;
            while (n_den < 3 && k < 100) begin tick(); k++; end
        end
        chk("abort_reach3", n_den, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_outs", outs(), 0);
        clr_mon();
        repeat (30) tick();
        chk("abort_nores", n_res, 0);
        issue(2);
        wait_done("abort_re", 100);
        chk("abort_re_res", n_res, 2);

        // start with abort in the same cycle stays idle
        tick();
        start = 1'b1; abort = 1'b1; cfg_rows = 10'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start", int'(busy), 0);

        // start during busy is ignored
        issue(3);
        start = 1'b1; cfg_rows = 10'd7;
        repeat (6) tick();
        start = 1'b0;
        wait_done("ignore", 100);
        chk("ignore_res", n_res, 3);
        chk("ignore_den", n_den, 3);

        // asynchronous reset in DRAIN
        issue(4);
        repeat (12) tick();
        chk("rstd_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1 chk("rstd_outs", outs(), 0);
        tick();
        reset = 1'b0;
        clr_mon();
        repeat (30) tick();
        chk("rstd_nores", n_res, 0);
        chk("rstd_idle", int'(busy), 0);

        // maximum tile
        issue(1023);
        wait_done("max", 2000);
        chk("max_den",   n_den, 1023);
        chk("max_res",   n_res, 1023);
        chk("max_ndone", n_done, 1);
        chk("max_len",   done_cyc - start_cyc + 1, 1 + 4 + 1023 + 20 + 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_blk_sequencer.md
# pe_blk_sequencer

Controller that sequences one matrix tile through the 16-block PE array of the MHA datapath. It loads weights (`is_wt` phase), streams a programmable number of data rows, and drains the systolic pipeline. It also produces a `res_valid` strobe aligned with the staged `acc_out`, so the result writer captures exactly one beat per streamed row. It sits between the MHA operand buffers and the PE array and is the sole driver of `is_wt`.

## Interface
Parameters:
- `bit_width`, 8, operand width.
- `systolic_depth`, 4, weight rows per PE block; also the number of weight-load beats.
- `systolic_column`, 16, columns per PE block.
- `stage_lat`, 1, cycles added by the accumulator staging register.
- `row_width`, 10, width of the row-count config (max 1023 rows).
- `PIPE_LAT`, `systolic_depth + systolic_column - 1 + stage_lat` (derived, not overridable), latency from data row issued to its result valid.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin tile; sampled only in IDLE.
- `cfg_rows` in `row_width`: rows to stream; latched on accepted `start`. A value of 0 means no STREAM phase.
- `abort` in 1: synchronous; returns the block to IDLE next cycle from any state.
- `wt_valid` in 1 / `wt_ready` out 1: weight-beat handshake.
- `dat_valid` in 1 / `dat_ready` out 1: data-row handshake.
- `is_wt` out 1: drives the PE array weight-load enable.
- `dat_en` out 1: high when the PE array consumes a real data row this cycle. When low, the upstream mux feeds zeros.
- `res_valid` out 1: `acc_out` holds the result of one row this cycle.
- `busy` out 1, `done` out 1 (one-cycle pulse).

## Operation
States, with encoding in the package: IDLE=0, LOAD_WT=1, STREAM=2, DRAIN=3, DONE=4.
- **IDLE:**
  - `start` latches `cfg_rows` into `rows_q` and moves to LOAD_WT.
  - `start` while not in IDLE is ignored.
- **LOAD_WT:**
  - `wt_ready`=1.
  - `is_wt` = `wt_valid` & `wt_ready`. A beat transfers only on a handshake; stalls insert `is_wt`=0 cycles.
  - After `systolic_depth` beats: go to STREAM if `rows_q`≠0, otherwise go to DONE.
- **STREAM:**
  - `dat_ready`=1.
  - `dat_en` = `dat_valid`; each handshake increments `in_cnt`.
  - On the handshake that makes `in_cnt`==`rows_q`, go to DRAIN.
  - Bubbles (`dat_valid`=0) are allowed and propagate as bubbles in `res_valid`.
- **DRAIN:**
  - `dat_ready`=0, `dat_en`=0.
  - Wait until `out_cnt`==`rows_q`, then go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Valid pipe:**
  - `dat_en` enters a `PIPE_LAT`-deep shift register; its tail is `res_valid`.
  - Each `res_valid` increments `out_cnt`.
  - The pipe shifts every cycle in all states and is never stalled, because the PE array has no stall.
- **`busy`:** 1 in every state except IDLE.
- **abort:**
  - Clears the FSM, all counters and the valid pipe.
  - Takes priority over every transition, including a same-cycle `start`.

## Timing
Reset (asynchronous assert) and abort (next edge) values:
- State=IDLE.
- `is_wt`, `wt_ready`, `dat_ready`, `dat_en`, `res_valid`, `busy`, `done` = 0.
- Counters and the valid pipe = 0.

Handshake and output timing:
- All outputs are registered or decoded directly from state. `wt_ready`/`dat_ready` do not depend combinationally on `*_valid`.
- `is_wt` and `dat_en` are combinational AND of valid & ready, so they arrive in the same cycle as the beat.
- A row accepted at cycle t produces `res_valid` at t+`PIPE_LAT` (20 with defaults).

Cycle counts:
- Minimum tile length, with no stalls: 1 (IDLE→LOAD_WT) + `systolic_depth` + `rows_q` + `PIPE_LAT` + 1 (DONE) cycles.
- Counters are `row_width` wide and never wrap, since `in_cnt`≤`rows_q`.
- The weight-beat counter is `$clog2(systolic_depth)+1` bits.

Boundary conditions:
- A simultaneous final STREAM handshake and `res_valid` are both counted.
- DRAIN exit tests the updated `out_cnt`.

## Structure
- Package `pe_seq_pkg` holds:
  - the state enum localparams;
  - the `PIPE_LAT` computation function;
  - the default `stage_lat`.
- One sub-module, `pe_valid_pipe` (parameter `DEPTH`; ports `clk`, `reset`, `clr`, `in`, `out`), holds the shift register so it can be reused by other MHA controllers.

## Test plan
- **Basic tile.** Reset, then `start` with `cfg_rows`=8, valids always high → `is_wt` high 4 cycles, `dat_en` 8 cycles, `res_valid` 8 consecutive cycles beginning 20 cycles after the first `dat_en`, `done` 1 cycle later. Total 34 cycles from the `start` cycle.
- **Stalls.** `wt_valid` toggling 1010…, `dat_valid` with 2-cycle bubbles, `cfg_rows`=5 → exactly 4 `is_wt` pulses and 5 `res_valid` pulses; the `res_valid` gap pattern equals the `dat_en` pattern delayed 20 cycles.
- **Zero rows.** `cfg_rows`=0 → 4 weight beats, then DONE; `res_valid` never asserts.
- **Abort.** Abort mid-STREAM after 3 of 10 rows → next cycle IDLE, `busy`=0, `res_valid`=0 thereafter. A new `start` with `cfg_rows`=2 yields exactly 2 results.
- **Reset mid-DRAIN.** Assert `reset` asynchronously between edges → all outputs 0 immediately. `start` during `busy` is ignored, with `rows_q` unchanged.
- **Maximum size.** `cfg_rows`=1023 → 1023 `res_valid` pulses, `done` once, no counter wrap.
